// File: rtl/rx_acl_match_engine_pkg.sv
// Shared switch-core definitions for the RX ACL match engine:
// result field layout, config FSM encoding and field helpers.
package rx_acl_match_engine_pkg;

    localparam int ACL_RSLT_W       = 16;
    localparam int ACL_CNT_W        = 16;

    localparam int RSLT_FRMTYPE_LSB = 0;
    localparam int RSLT_FRMTYPE_W   = 8;
    localparam int RSLT_PORTMAP_LSB = 8;
    localparam int RSLT_PORTMAP_W   = 8;

    localparam logic [0:0] CFG_IDLE  = 1'b0;
    localparam logic [0:0] CFG_CLEAR = 1'b1;

    function automatic logic [RSLT_FRMTYPE_W-1:0] rslt_frmtype(input logic [ACL_RSLT_W-1:0] rslt);
        return rslt[RSLT_FRMTYPE_LSB +: RSLT_FRMTYPE_W];
    endfunction

endpackage

// File: rtl/acl_item_cmp.sv
// One ACL entry: byte pattern/mask storage and the per-frame live bit.
// live is the combinational verdict of this entry including the current beat.
module acl_item_cmp
    import rx_acl_match_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATCH_BYTES = 32,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int ADDR_W     = $clog2(MATCH_BYTES),
    localparam int OFF_W      = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [7:0]            din,
    input  logic [7:0]            mask,
    input  logic                  beat,
    input  logic                  sof,
    input  logic                  last,
    input  logic                  abort,
    input  logic [OFF_W-1:0]      off,
    input  logic [OFF_W-1:0]      next_off,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [LANES-1:0]      keep,
    output logic                  live
);

    logic [7:0] pat_mem  [MATCH_BYTES];
    logic [7:0] mask_mem [MATCH_BYTES];
    logic       live_q;

    // NOTE: the pattern store has no reset; a zero mask makes its contents don't-care.
    always_ff @(posedge clk) begin
        if (we) begin
            pat_mem[waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int j = 0; j < MATCH_BYTES; j++) begin
                mask_mem[j] <= 8'h00;
            end
        end else if (we) begin
            mask_mem[waddr] <= mask;
        end
    end

    // NOTE: live is given its default first so no path leaves it unassigned (no latch).
    always_comb begin
        live = sof ? 1'b1 : live_q;
        for (int k = 0; k < LANES; k++) begin
            if (keep[k] && (int'(off) + k) < MATCH_BYTES) begin
                if (((data[8*k +: 8] ^ pat_mem[ADDR_W'(int'(off) + k)]) &
                     mask_mem[ADDR_W'(int'(off) + k)]) != 8'h00) begin
                    live = 1'b0;
                end
            end
        end
        // Bytes a short frame never delivered only match when fully masked out.
        if (last) begin
            for (int j = 0; j < MATCH_BYTES; j++) begin
                if (j >= int'(next_off) && mask_mem[j] != 8'h00) begin
                    live = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            live_q <= 1'b0;
        end else if (beat) begin
            live_q <= live;
        end
    end

endmodule

// File: rtl/rx_acl_match_engine.sv
// RX ACL match engine: compares the first MATCH_BYTES of each frame against
// ITEM_NUM masked patterns and reports the lowest-index valid hit once per frame.
module rx_acl_match_engine
    import rx_acl_match_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ITEM_NUM    = 8,
    parameter int MATCH_BYTES = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_mac_port_link,
    input  logic [DATA_WIDTH-1:0]           i_mac_axi_data,
    input  logic [DATA_WIDTH/8-1:0]         i_mac_axi_data_keep,
    input  logic                            i_mac_axi_data_valid,
    output logic                            o_mac_axi_data_ready,
    input  logic                            i_mac_axi_data_last,
    input  logic                            i_acl_clr_list,
    output logic                            o_acl_list_rdy,
    input  logic [$clog2(ITEM_NUM)-1:0]     i_acl_item_sel,
    input  logic [$clog2(MATCH_BYTES)-1:0]  i_acl_item_waddr,
    input  logic [7:0]                      i_acl_item_din,
    input  logic [7:0]                      i_acl_item_mask,
    input  logic                            i_acl_item_we,
    input  logic [15:0]                     i_acl_item_rslt,
    input  logic                            i_acl_item_complete,
    output logic                            o_acl_vld,
    output logic                            o_acl_find_match,
    output logic [$clog2(ITEM_NUM)-1:0]     o_acl_hit_idx,
    output logic [7:0]                      o_acl_frmtype,
    output logic [15:0]                     o_acl_fetch_info,
    input  logic [$clog2(ITEM_NUM)-1:0]     i_acl_cnt_sel,
    output logic [15:0]                     o_acl_hit_cnt
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int SEL_W  = $clog2(ITEM_NUM);
    localparam int ADDR_W = $clog2(MATCH_BYTES);
    localparam int OFF_W  = ADDR_W + 1;
    localparam int PC_W   = $clog2(LANES + 1);

    logic [0:0]                         cfg_state;
    logic [SEL_W-1:0]                   clr_idx;
    logic [ITEM_NUM-1:0]                clr_hit;
    logic                               we_en;
    logic                               complete_en;
    logic [ITEM_NUM-1:0]                item_valid;
    logic [ACL_RSLT_W-1:0]              item_rslt [ITEM_NUM];
    logic [ITEM_NUM-1:0][ACL_CNT_W-1:0] hit_cnt_q;
    logic [ITEM_NUM-1:0]                live_vec;
    logic [ITEM_NUM-1:0]                hit_vec;
    logic [OFF_W-1:0]                   off_q;
    logic [OFF_W-1:0]                   next_off;
    logic [PC_W-1:0]                    keep_cnt;
    logic                               sof_q;
    logic                               beat;
    logic                               decide;
    logic                               find_any;
    logic [SEL_W-1:0]                   win_idx;

    assign o_mac_axi_data_ready = 1'b1;
    assign o_acl_list_rdy       = (cfg_state == CFG_IDLE);
    assign we_en                = i_acl_item_we & o_acl_list_rdy;
    assign complete_en          = i_acl_item_complete & o_acl_list_rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_state <= CFG_IDLE;
            clr_idx   <= '0;
        end else if (cfg_state == CFG_IDLE) begin
            if (i_acl_clr_list) begin
                cfg_state <= CFG_CLEAR;
                clr_idx   <= '0;
            end
        end else begin
            clr_idx <= clr_idx + SEL_W'(1);
            if (clr_idx == SEL_W'(ITEM_NUM - 1)) begin
                cfg_state <= CFG_IDLE;
            end
        end
    end

    always_comb begin
        clr_hit = '0;
        for (int i = 0; i < ITEM_NUM; i++) begin
            clr_hit[i] = (cfg_state == CFG_CLEAR) && (clr_idx == SEL_W'(i));
        end
    end

    // Commit wins over a same-cycle write so a write+commit leaves the entry valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            item_valid <= '0;
        end else begin
            for (int i = 0; i < ITEM_NUM; i++) begin
                if (clr_hit[i]) begin
                    item_valid[i] <= 1'b0;
                end else if (complete_en && i_acl_item_sel == SEL_W'(i)) begin
                    item_valid[i] <= 1'b1;
                end else if (we_en && i_acl_item_sel == SEL_W'(i)) begin
                    item_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (complete_en) begin
            item_rslt[i_acl_item_sel] <= i_acl_item_rslt;
        end
    end

    always_comb begin
        keep_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            keep_cnt = keep_cnt + PC_W'(i_mac_axi_data_keep[k]);
        end
    end

    always_comb begin
        if (int'(off_q) + int'(keep_cnt) >= MATCH_BYTES) begin
            next_off = OFF_W'(MATCH_BYTES);
        end else begin
            next_off = off_q + OFF_W'(keep_cnt);
        end
    end

    assign beat   = i_mac_axi_data_valid & i_mac_port_link;
    assign decide = beat && (off_q < OFF_W'(MATCH_BYTES)) &&
                    (i_mac_axi_data_last || next_off == OFF_W'(MATCH_BYTES));

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_mac_port_link) begin
            off_q <= '0;
            sof_q <= 1'b1;
        end else if (beat) begin
            off_q <= i_mac_axi_data_last ? '0 : next_off;
            sof_q <= i_mac_axi_data_last;
        end
    end

    for (genvar i = 0; i < ITEM_NUM; i++) begin : g_item
        acl_item_cmp #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MATCH_BYTES (MATCH_BYTES)
        ) u_cmp (
            .clk      (i_clk),
            .rst      (i_rst),
            .clr      (clr_hit[i]),
            .we       (we_en && i_acl_item_sel == SEL_W'(i)),
            .waddr    (i_acl_item_waddr),
            .din      (i_acl_item_din),
            .mask     (i_acl_item_mask),
            .beat     (beat),
            .sof      (sof_q),
            .last     (i_mac_axi_data_last),
            .abort    (!i_mac_port_link),
            .off      (off_q),
            .next_off (next_off),
            .data     (i_mac_axi_data),
            .keep     (i_mac_axi_data_keep),
            .live     (live_vec[i])
        );
    end

    // A list being cleared never produces a hit.
    assign hit_vec = live_vec & item_valid & {ITEM_NUM{o_acl_list_rdy}};

    always_comb begin
        find_any = |hit_vec;
        win_idx  = '0;
        for (int i = ITEM_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_acl_vld        <= 1'b0;
            o_acl_find_match <= 1'b0;
            o_acl_hit_idx    <= '0;
            o_acl_frmtype    <= '0;
            o_acl_fetch_info <= '0;
        end else begin
            o_acl_vld <= decide;
            if (decide) begin
                o_acl_find_match <= find_any;
                o_acl_hit_idx    <= win_idx;
                o_acl_frmtype    <= find_any ? rslt_frmtype(item_rslt[win_idx]) : '0;
                o_acl_fetch_info <= find_any ? item_rslt[win_idx] : '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ITEM_NUM; i++) begin
                if (clr_hit[i]) begin
                    hit_cnt_q[i] <= '0;
                end else if (decide && find_any && win_idx == SEL_W'(i) && hit_cnt_q[i] != '1) begin
                    hit_cnt_q[i] <= hit_cnt_q[i] + ACL_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_acl_hit_cnt <= '0;
        end else begin
            o_acl_hit_cnt <= hit_cnt_q[i_acl_cnt_sel];
        end
    end

endmodule

// File: tb/tb_rx_acl_match_engine.sv
// Directed bench for rx_acl_match_engine: entry programming, hit priority,
// short frames, link abort, list clear and hit-counter saturation.
module tb_rx_acl_match_engine;
    import rx_acl_match_engine_pkg::*;

    localparam int DATA_WIDTH  = 8;
    localparam int ITEM_NUM    = 8;
    localparam int MATCH_BYTES = 32;
    localparam int SEL_W       = $clog2(ITEM_NUM);
    localparam int ADDR_W      = $clog2(MATCH_BYTES);

    logic                    i_clk;
    logic                    i_rst;
    logic                    i_mac_port_link;
    logic [DATA_WIDTH-1:0]   i_mac_axi_data;
    logic [DATA_WIDTH/8-1:0] i_mac_axi_data_keep;
    logic                    i_mac_axi_data_valid;
    logic                    o_mac_axi_data_ready;
    logic                    i_mac_axi_data_last;
    logic                    i_acl_clr_list;
    logic                    o_acl_list_rdy;
    logic [SEL_W-1:0]        i_acl_item_sel;
    logic [ADDR_W-1:0]       i_acl_item_waddr;
    logic [7:0]              i_acl_item_din;
    logic [7:0]              i_acl_item_mask;
    logic                    i_acl_item_we;
    logic [ACL_RSLT_W-1:0]   i_acl_item_rslt;
    logic                    i_acl_item_complete;
    logic                    o_acl_vld;
    logic                    o_acl_find_match;
    logic [SEL_W-1:0]        o_acl_hit_idx;
    logic [7:0]              o_acl_frmtype;
    logic [15:0]             o_acl_fetch_info;
    logic [SEL_W-1:0]        i_acl_cnt_sel;
    logic [15:0]             o_acl_hit_cnt;

    rx_acl_match_engine #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ITEM_NUM    (ITEM_NUM),
        .MATCH_BYTES (MATCH_BYTES)
    ) dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_mac_port_link      (i_mac_port_link),
        .i_mac_axi_data       (i_mac_axi_data),
        .i_mac_axi_data_keep  (i_mac_axi_data_keep),
        .i_mac_axi_data_valid (i_mac_axi_data_valid),
        .o_mac_axi_data_ready (o_mac_axi_data_ready),
        .i_mac_axi_data_last  (i_mac_axi_data_last),
        .i_acl_clr_list       (i_acl_clr_list),
        .o_acl_list_rdy       (o_acl_list_rdy),
        .i_acl_item_sel       (i_acl_item_sel),
        .i_acl_item_waddr     (i_acl_item_waddr),
        .i_acl_item_din       (i_acl_item_din),
        .i_acl_item_mask      (i_acl_item_mask),
        .i_acl_item_we        (i_acl_item_we),
        .i_acl_item_rslt      (i_acl_item_rslt),
        .i_acl_item_complete  (i_acl_item_complete),
        .o_acl_vld            (o_acl_vld),
        .o_acl_find_match     (o_acl_find_match),
        .o_acl_hit_idx        (o_acl_hit_idx),
        .o_acl_frmtype        (o_acl_frmtype),
        .o_acl_fetch_info     (o_acl_fetch_info),
        .i_acl_cnt_sel        (i_acl_cnt_sel),
        .o_acl_hit_cnt        (o_acl_hit_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks    = 0;
    int n_fail      = 0;
    int pulse_count = 0;
    int pulse_cyc   = 0;

    always @(negedge i_clk) begin
        if (o_acl_vld) begin
            pulse_count++;
            pulse_cyc = cyc;
        end
    end

    logic [7:0] frm [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic cfg_byte(input int sel, input int addr, input logic [7:0] din, input logic [7:0] mask);
        i_acl_item_sel   = SEL_W'(sel);
        i_acl_item_waddr = ADDR_W'(addr);
        i_acl_item_din   = din;
        i_acl_item_mask  = mask;
        i_acl_item_we    = 1'b1;
        @(negedge i_clk);
        i_acl_item_we    = 1'b0;
    endtask

    task automatic commit(input int sel, input logic [15:0] rslt);
        i_acl_item_sel      = SEL_W'(sel);
        i_acl_item_rslt     = rslt;
        i_acl_item_complete = 1'b1;
        @(negedge i_clk);
        i_acl_item_complete = 1'b0;
    endtask

    task automatic send_frame(input int len, input int decide_beat, output int exp_cyc);
        exp_cyc = -1;
        for (int b = 0; b < len; b++) begin
            i_mac_axi_data_valid = 1'b1;
            i_mac_axi_data       = frm[b];
            i_mac_axi_data_last  = (b == len - 1);
            if (b == decide_beat) exp_cyc = cyc + 1;
            @(negedge i_clk);
        end
        i_mac_axi_data_valid = 1'b0;
        i_mac_axi_data_last  = 1'b0;
    endtask

    task automatic expect_verdict(input string tag, input int base, input int exp_cyc,
                                  input logic m, input logic [SEL_W-1:0] idx,
                                  input logic [7:0] ft, input logic [15:0] info);
        idle(3);
        check({tag, "_pulses"},  pulse_count - base, 1);
        check({tag, "_latency"}, pulse_cyc, exp_cyc);
        check({tag, "_match"},   o_acl_find_match, m);
        check({tag, "_idx"},     o_acl_hit_idx, idx);
        check({tag, "_frmtype"}, o_acl_frmtype, ft);
        check({tag, "_info"},    o_acl_fetch_info, info);
    endtask

    task automatic read_cnt(input string tag, input int sel, input logic [15:0] exp);
        i_acl_cnt_sel = SEL_W'(sel);
        idle(2);
        check(tag, o_acl_hit_cnt, exp);
    endtask

    task automatic fill_frame(input logic [7:0] v);
        for (int j = 0; j < 64; j++) frm[j] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int exp_cyc;
        int low;
        logic [ITEM_NUM-1:0][15:0] fcnt;

        i_rst                = 1'b1;
        i_mac_port_link      = 1'b1;
        i_mac_axi_data       = '0;
        i_mac_axi_data_keep  = '1;
        i_mac_axi_data_valid = 1'b0;
        i_mac_axi_data_last  = 1'b0;
        i_acl_clr_list       = 1'b0;
        i_acl_item_sel       = '0;
        i_acl_item_waddr     = '0;
        i_acl_item_din       = '0;
        i_acl_item_mask      = '0;
        i_acl_item_we        = 1'b0;
        i_acl_item_rslt      = '0;
        i_acl_item_complete  = 1'b0;
        i_acl_cnt_sel        = '0;

        idle(3);
        check("rst_rdy",     o_acl_list_rdy, 1);
        check("rst_vld",     o_acl_vld, 0);
        check("rst_match",   o_acl_find_match, 0);
        check("rst_idx",     o_acl_hit_idx, 0);
        check("rst_frmtype", o_acl_frmtype, 0);
        check("rst_info",    o_acl_fetch_info, 0);
        check("rst_hit_cnt", o_acl_hit_cnt, 0);
        check("axi_ready",   o_mac_axi_data_ready, 1);
        i_rst = 1'b0;
        idle(2);

        // Entry 2 matches six leading 0xFF bytes; 64-byte broadcast frame.
        for (int j = 0; j < 6; j++) cfg_byte(2, j, 8'hFF, 8'hFF);
        commit(2, 16'h0305);
        idle(2);
        fill_frame(8'hFF);
        base = pulse_count;
        send_frame(64, 31, exp_cyc);
        expect_verdict("bcast", base, exp_cyc, 1'b1, 3'd2, 8'h05, 16'h0305);
        check("bcast_hold_vld_low", o_acl_vld, 0);
        read_cnt("bcast_cnt2", 2, 16'd1);

        // Entries 1 and 3 both match: lowest index wins; then only entry 3.
        cfg_byte(1, 0, 8'hAA, 8'hFF);
        commit(1, 16'h0111);
        cfg_byte(3, 1, 8'h50, 8'hF0);
        commit(3, 16'h0833);
        idle(2);
        fill_frame(8'h00);
        frm[0] = 8'hAA;
        frm[1] = 8'h5A;
        base = pulse_count;
        send_frame(40, 31, exp_cyc);
        expect_verdict("prio", base, exp_cyc, 1'b1, 3'd1, 8'h11, 16'h0111);
        frm[0] = 8'hAB;
        frm[1] = 8'h5F;
        base = pulse_count;
        send_frame(40, 31, exp_cyc);
        expect_verdict("nibble", base, exp_cyc, 1'b1, 3'd3, 8'h33, 16'h0833);
        read_cnt("cnt1", 1, 16'd1);
        read_cnt("cnt3", 3, 16'd1);

        // Entry 0 compares 20 bytes: a 20-byte frame hits, a 12-byte frame misses.
        for (int j = 0; j < 20; j++) cfg_byte(0, j, 8'(j + 16), 8'hFF);
        commit(0, 16'h0A0B);
        idle(2);
        for (int j = 0; j < 64; j++) frm[j] = 8'(j + 16);
        base = pulse_count;
        send_frame(20, 19, exp_cyc);
        expect_verdict("short20", base, exp_cyc, 1'b1, 3'd0, 8'h0B, 16'h0A0B);
        base = pulse_count;
        send_frame(12, 11, exp_cyc);
        expect_verdict("short12", base, exp_cyc, 1'b0, 3'd0, 8'h00, 16'h0000);

        // Link drop after 10 bytes aborts; the following frame decides on its own byte 31.
        fill_frame(8'hFF);
        base = pulse_count;
        for (int b = 0; b < 10; b++) begin
            i_mac_axi_data_valid = 1'b1;
            i_mac_axi_data       = 8'hFF;
            i_mac_axi_data_last  = 1'b0;
            @(negedge i_clk);
        end
        i_mac_port_link = 1'b0;
        idle(3);
        i_mac_axi_data_valid = 1'b0;
        i_mac_port_link      = 1'b1;
        idle(3);
        check("linkdrop_no_vld", pulse_count - base, 0);
        base = pulse_count;
        send_frame(64, 31, exp_cyc);
        expect_verdict("after_drop", base, exp_cyc, 1'b1, 3'd2, 8'h05, 16'h0305);

        // Clear the list; a write+commit to entry 0 during the walk is ignored.
        i_acl_clr_list = 1'b1;
        @(negedge i_clk);
        i_acl_clr_list = 1'b0;
        low = 0;
        for (int k = 0; k < 16; k++) begin
            if (!o_acl_list_rdy) low++;
            i_acl_item_sel      = '0;
            i_acl_item_waddr    = '0;
            i_acl_item_din      = 8'h00;
            i_acl_item_mask     = 8'h00;
            i_acl_item_rslt     = 16'h0777;
            i_acl_item_we       = (k == 3);
            i_acl_item_complete = (k == 3);
            @(negedge i_clk);
        end
        i_acl_item_we       = 1'b0;
        i_acl_item_complete = 1'b0;
        check("clear_rdy_low_cycles", low, 8);
        check("clear_rdy_back", o_acl_list_rdy, 1);
        read_cnt("clear_cnt2", 2, 16'd0);
        base = pulse_count;
        send_frame(64, 31, exp_cyc);
        expect_verdict("after_clear", base, exp_cyc, 1'b0, 3'd0, 8'h00, 16'h0000);

        // Counter saturation: preload entry 2 to 0xFFFF and hit it again.
        for (int j = 0; j < 6; j++) cfg_byte(2, j, 8'hFF, 8'hFF);
        commit(2, 16'h0305);
        fcnt    = '0;
        fcnt[2] = 16'hFFFF;
        force dut.hit_cnt_q = fcnt;
        idle(1);
        release dut.hit_cnt_q;
        read_cnt("sat_preload", 2, 16'hFFFF);
        base = pulse_count;
        send_frame(64, 31, exp_cyc);
        expect_verdict("sat_hit", base, exp_cyc, 1'b1, 3'd2, 8'h05, 16'h0305);
        read_cnt("sat_cnt2", 2, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_acl_match_engine.md
RX_ACL_MATCH_ENGINE -- requirements
Module: rx_acl_match_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: stream data width in bits, a multiple of 8; lane 0 (bits 7:0) carries the earliest byte of a beat.
REQ-002 Parameter ITEM_NUM, default 8: number of ACL entries, 2..32.
REQ-003 Parameter MATCH_BYTES, default 32: compare window per entry in bytes, a power of 2, at most 64.
REQ-004 Ports: i_clk  in  1  single clock; i_rst  in  1  reset, synchronous, active-high.
REQ-005 Port i_mac_port_link  in  1  link up.
REQ-006 Ports: i_mac_axi_data  in  DATA_WIDTH; i_mac_axi_data_keep  in  DATA_WIDTH/8 (contiguous from lane 0); i_mac_axi_data_valid  in  1; o_mac_axi_data_ready  out  1; i_mac_axi_data_last  in  1.
REQ-007 Ports: i_acl_clr_list  in  1  clear pulse; o_acl_list_rdy  out  1  config idle.
REQ-008 Port i_acl_item_sel  in  clog2(ITEM_NUM)  entry select.
REQ-009 Port i_acl_item_waddr  in  clog2(MATCH_BYTES)  byte offset.
REQ-010 Ports: i_acl_item_din  in  8  compare byte; i_acl_item_mask  in  8  bit mask, 1 = compare; i_acl_item_we  in  1  write strobe.
REQ-011 Ports: i_acl_item_rslt  in  16  result, [7:0] frame type, [15:8] forward port map; i_acl_item_complete  in  1  commit pulse.
REQ-012 Ports: o_acl_vld  out  1; o_acl_find_match  out  1; o_acl_hit_idx  out  clog2(ITEM_NUM); o_acl_frmtype  out  8; o_acl_fetch_info  out  16.
REQ-013 Ports: i_acl_cnt_sel  in  clog2(ITEM_NUM); o_acl_hit_cnt  out  16.

Function
REQ-014 o_mac_axi_data_ready SHALL be constant 1; a beat is accepted when valid is high.
REQ-015 A byte offset counter SHALL advance by popcount(keep) per beat, saturate at MATCH_BYTES, and reset to 0 after a last beat.
REQ-016 A per-entry live vector SHALL be set to all-ones at frame start and clear entry i's bit on any kept byte at offset < MATCH_BYTES where (byte XOR pattern) AND mask is nonzero.
REQ-017 The verdict SHALL be taken on the beat on which the offset reaches MATCH_BYTES or the beat with last high, whichever comes first, exactly once per frame.
REQ-018 For frames shorter than MATCH_BYTES, unreceived bytes SHALL mismatch unless their mask is 0x00.
REQ-019 o_acl_vld SHALL pulse for one cycle, one cycle after the deciding beat (latency 1).
REQ-020 With that pulse, find_match SHALL indicate a valid live entry exists, and hit_idx, frmtype and fetch_info SHALL reflect the lowest-index such entry.
REQ-021 On a miss, hit_idx, frmtype and fetch_info SHALL be 0.
REQ-022 Outputs SHALL hold their values between pulses.
REQ-023 Link low SHALL abort the current frame, producing no verdict and resetting offset and live vector; beats are ignored while link is low.
REQ-024 i_acl_item_we SHALL write pattern and mask at (sel, waddr) and clear sel's valid bit in the same cycle.
REQ-025 complete SHALL latch rslt and set the valid bit.
REQ-026 we and complete on the same entry in the same cycle SHALL perform the write and leave the entry valid.
REQ-027 Config FSM states IDLE and CLEAR: i_acl_clr_list in IDLE SHALL enter CLEAR, walking one entry per cycle (clearing valid, mask, counter) for ITEM_NUM cycles, then return to IDLE.
REQ-028 o_acl_list_rdy SHALL be low in CLEAR; config inputs SHALL be ignored in CLEAR.
REQ-029 A verdict taken during CLEAR SHALL report find_match=0.
REQ-030 Each hit SHALL increment the winning entry's 16-bit counter, saturating at 0xFFFF.
REQ-031 o_acl_hit_cnt SHALL be registered, one cycle after i_acl_cnt_sel.

Reset
REQ-032 i_rst SHALL clear all valid bits, masks, counters, offset and live vector.
REQ-033 On i_rst, FSM SHALL enter IDLE, o_acl_list_rdy=1, o_acl_vld=0, and all other outputs SHALL be 0.
REQ-034 Reset mid-frame SHALL discard the frame with no verdict.

Structure
REQ-035 The result field offsets, FSM state encoding and the ACL_RSLT_W=16 constant SHALL live in the shared switch-core package.
REQ-036 One sub-module, acl_item_cmp, SHALL hold a single entry's pattern/mask storage and live bit; it SHALL be instantiated ITEM_NUM times.

Verification
REQ-037 Entry 2: bytes 0-5 = FF, mask FF, rest mask 00, rslt 0x0305; 64-byte broadcast -> vld with match=1, idx=2, frmtype 0x05, fetch_info 0x0305, hit_cnt[2]=1.
REQ-038 Entries 1 and 3 both match -> idx=1.
REQ-039 Entry 0 with 20 compared bytes; 12-byte frame -> match=0 at the last+1 cycle.
REQ-040 Clear pulse -> rdy low 8 cycles; the frame after clear misses; we during CLEAR is ignored.
REQ-041 Link drop mid-frame -> no vld; the next frame gets a correct verdict.
REQ-042 Force counter to 0xFFFF, hit again -> counter stays 0xFFFF.
